// File: rtl/wide_add_seq_if.sv
// Operand intake and result output bundle for the sequential wide adder.
interface wide_add_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = WIDTH * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  // The adder itself.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one WIDTH-bit ripple slice per clock, LSB slice first,
// carry registered between slices. Result held until the consumer takes it.
module wide_add_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  wide_add_seq_if.slave bus
);
  localparam int unsigned W    = WIDTH * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  logic [WIDTH-1:0] a_sl, b_sl;
  logic [WIDTH:0]   slice_res;

  // Select the operand slices addressed by the current slice index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IdxW'(k)) begin
        a_sl = a_q[k*WIDTH +: WIDTH];
        b_sl = b_q[k*WIDTH +: WIDTH];
      end
    end
  end

  assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{WIDTH{1'b0}}, carry_q};

  // Next-state logic: operand capture, per-slice accumulation, result handshake.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == IdxW'(k)) begin
            sum_d[k*WIDTH +: WIDTH] = slice_res[WIDTH-1:0];
          end
        end
        carry_d = slice_res[WIDTH];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = slice_res[WIDTH];
          // Carry into the MSB is a^b^s there; overflow is that XOR carry out.
          ovf_d   = a_sl[WIDTH-1] ^ b_sl[WIDTH-1] ^ slice_res[WIDTH-1] ^ slice_res[WIDTH];
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq: a 4x32 instance and a 1x128 instance share
// stimulus; 'sel' routes handshakes and observed outputs to one of them.
module tb_wide_add_seq;
  localparam int unsigned W = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         sel;
  logic         in_valid, out_ready, in_cin;
  logic [W-1:0] in_a, in_b;

  wide_add_seq_if #(.WIDTH(32),  .WORDS(4)) bus4 ();
  wide_add_seq_if #(.WIDTH(128), .WORDS(1)) bus1 ();

  wide_add_seq #(.WIDTH(32), .WORDS(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  wide_add_seq #(.WIDTH(128), .WORDS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  assign bus4.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus4.out_ready = out_ready & ~sel;
  assign bus1.out_ready = out_ready & sel;
  assign bus4.in_a      = in_a;
  assign bus1.in_a      = in_a;
  assign bus4.in_b      = in_b;
  assign bus1.in_b      = in_b;
  assign bus4.in_cin    = in_cin;
  assign bus1.in_cin    = in_cin;

  logic         r_in_ready, r_out_valid, r_cout, r_ovf, r_busy;
  logic [W-1:0] r_sum;

  always_comb begin
    r_in_ready  = sel ? bus1.in_ready  : bus4.in_ready;
    r_out_valid = sel ? bus1.out_valid : bus4.out_valid;
    r_sum       = sel ? bus1.out_sum   : bus4.out_sum;
    r_cout      = sel ? bus1.out_cout  : bus4.out_cout;
    r_ovf       = sel ? bus1.out_ovf   : bus4.out_ovf;
    r_busy      = sel ? bus1.busy      : bus4.busy;
  end

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] sum, input logic cout,
                         input logic ovf);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.cin = cin; v.sum = sum; v.cout = cout; v.ovf = ovf;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the selected DUT; operand pins are scrambled after accept.
  task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output logic [W-1:0] sum, output logic cout,
                         output logic ovf, output int lat);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    check1({tag, " in_ready before accept"}, r_in_ready, 1'b1);
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin;
    lat = 0;
    while (!r_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check1({tag, " out_valid seen"}, r_out_valid, 1'b1);
    sum = r_sum; cout = r_cout; ovf = r_ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1({tag, " out_valid after take"}, r_out_valid, 1'b0);
    check1({tag, " in_ready after take"}, r_in_ready, 1'b1);
  endtask

  // in_valid held high, out_ready held high, three random operand sets.
  task automatic back_to_back(input logic s, input int words);
    logic [W-1:0] oa[3], ob[3], es[3];
    logic         oc[3], ec[3], eo[3];
    logic [W:0]   full;
    int           acc_edge[3];
    int           nacc, nres, cyc;
    sel = s;
    for (int i = 0; i < 3; i++) begin
      oa[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      ob[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      oc[i] = 1'($urandom_range(0, 1));
      full  = {1'b0, oa[i]} + {1'b0, ob[i]} + {{W{1'b0}}, oc[i]};
      es[i] = full[W-1:0];
      ec[i] = full[W];
      eo[i] = (oa[i][W-1] == ob[i][W-1]) && (es[i][W-1] != oa[i][W-1]);
      acc_edge[i] = 0;
    end
    nacc = 0; nres = 0; cyc = 0;
    out_ready = 1'b1;
    while (nres < 3 && cyc < 200) begin
      if (nacc < 3) begin
        in_valid = 1'b1; in_a = oa[nacc]; in_b = ob[nacc]; in_cin = oc[nacc];
        if (r_in_ready) begin
          acc_edge[nacc] = cyc + 1;
          nacc++;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (r_out_valid) begin
        check($sformatf("b2b w%0d sum %0d", words, nres), r_sum, es[nres]);
        check1($sformatf("b2b w%0d cout %0d", words, nres), r_cout, ec[nres]);
        check1($sformatf("b2b w%0d ovf %0d", words, nres), r_ovf, eo[nres]);
        check_int($sformatf("b2b w%0d latency %0d", words, nres), cyc - acc_edge[nres], words);
        nres++;
        n_vec++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_int($sformatf("b2b w%0d results", words), nres, 3);
    check_int($sformatf("b2b w%0d spacing 0-1", words), acc_edge[1] - acc_edge[0], words + 2);
    check_int($sformatf("b2b w%0d spacing 1-2", words), acc_edge[2] - acc_edge[1], words + 2);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sum;
    logic         cout, ovf, seen;
    int           lat;

    sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_cin = 1'b0; in_a = '0; in_b = '0;

    add_vec("ripple", 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h0, 1'b1,
            128'h0, 1'b1, 1'b0);
    add_vec("sovf", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0,
            128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1);
    add_vec("slices", 128'h00000001_FFFFFFFF_00000000_80000000,
            128'h00000001_00000001_00000000_80000000, 1'b0,
            128'h00000003_00000000_00000001_00000000, 1'b0, 1'b0);
    add_vec("negovf", 128'h80000000_00000000_00000000_00000000,
            128'h80000000_00000000_00000000_00000000, 1'b0, 128'h0, 1'b1, 1'b1);
    add_vec("m1m1c1", 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b0);
    add_vec("small", 128'd5, 128'd7, 1'b0, 128'd12, 1'b0, 1'b0);
    add_vec("zero", 128'h0, 128'h0, 1'b0, 128'h0, 1'b0, 1'b0);
    add_vec("cinonly", 128'h0, 128'h0, 1'b1, 128'h1, 1'b0, 1'b0);

    // Reset state.
    #2 rst_n = 1'b0;
    tick();
    tick();
    check1("reset out_valid", r_out_valid, 1'b0);
    check("reset out_sum", r_sum, '0);
    check1("reset out_cout", r_cout, 1'b0);
    check1("reset out_ovf", r_ovf, 1'b0);
    check1("reset busy", r_busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check1("post-reset in_ready", r_in_ready, 1'b1);

    // out_ready while idle does nothing.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("idle out_ready busy", r_busy, 1'b0);
    check1("idle out_ready out_valid", r_out_valid, 1'b0);

    // Table-driven vectors on the 4-slice instance.
    foreach (vq[i]) begin
      run_txn(vq[i].name, vq[i].a, vq[i].b, vq[i].cin, sum, cout, ovf, lat);
      n_vec++;
      check({vq[i].name, " sum"}, sum, vq[i].sum);
      check1({vq[i].name, " cout"}, cout, vq[i].cout);
      check1({vq[i].name, " ovf"}, ovf, vq[i].ovf);
      check_int({vq[i].name, " latency"}, lat, 4);
    end

    // Backpressure: result held 5 cycles, new offers ignored meanwhile.
    in_a = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF; in_b = 128'h1; in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!r_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_vec++;
    check1("bp out_valid rises", r_out_valid, 1'b1);
    in_valid = 1'b1; in_a = 128'h3; in_b = 128'h4;
    for (int i = 0; i < 5; i++) begin
      check1($sformatf("bp out_valid c%0d", i), r_out_valid, 1'b1);
      check($sformatf("bp sum c%0d", i), r_sum, 128'h80000000_00000000_00000000_00000000);
      check1($sformatf("bp cout c%0d", i), r_cout, 1'b0);
      check1($sformatf("bp ovf c%0d", i), r_ovf, 1'b1);
      check1($sformatf("bp in_ready c%0d", i), r_in_ready, 1'b0);
      check1($sformatf("bp busy c%0d", i), r_busy, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check1("bp out_valid after take", r_out_valid, 1'b0);
    check1("bp in_ready after take", r_in_ready, 1'b1);
    check1("bp no accept on take edge", r_busy, 1'b0);
    tick();
    check1("bp still idle", r_busy, 1'b0);

    // Reset two cycles into a run.
    in_a = 128'h11111111_11111111_11111111_11111111; in_b = 128'h0; in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check1("mid-run busy", r_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset sum", r_sum, '0);
    check1("async reset out_valid", r_out_valid, 1'b0);
    check1("async reset busy", r_busy, 1'b0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | r_out_valid;
      tick();
    end
    check1("no valid after reset", seen, 1'b0);
    check1("in_ready after reset", r_in_ready, 1'b1);
    run_txn("rst 5+7", 128'd5, 128'd7, 1'b0, sum, cout, ovf, lat);
    n_vec++;
    check("rst 5+7 sum", sum, 128'd12);
    check_int("rst 5+7 latency", lat, 4);

    // Back-to-back on both slice counts.
    back_to_back(1'b0, 4);
    back_to_back(1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
